// File: rtl/fc_stream_layer_if.sv
// Stream, weight-load and result signals of the fully-connected classifier head.
// The master drives pixels and weights; the slave (the layer) drives results.
interface fc_stream_layer_if #(
    parameter int IN_LEN   = 16,
    parameter int NUM_OUT  = 4,
    parameter int DATA_W   = 22,
    parameter int WEIGHT_W = 8
);
    localparam int AW = (NUM_OUT * IN_LEN > 1) ? $clog2(NUM_OUT * IN_LEN) : 1;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic                       start_signal;
    logic                       pixel_valid;
    logic signed [DATA_W-1:0]   pixel_in;
    logic                       weight_we;
    logic [AW-1:0]              weight_addr;
    logic signed [WEIGHT_W-1:0] weight_data;
    logic signed [DATA_W-1:0]   result_out;
    logic [IW-1:0]              result_index;
    logic                       result_valid;
    logic                       done_signal;
    logic                       overrun_error;

    modport master (
        output start_signal, pixel_valid, pixel_in, weight_we, weight_addr, weight_data,
        input  result_out, result_index, result_valid, done_signal, overrun_error
    );

    modport slave (
        input  start_signal, pixel_valid, pixel_in, weight_we, weight_addr, weight_data,
        output result_out, result_index, result_valid, done_signal, overrun_error
    );
endinterface

// File: rtl/fc_stream_layer.sv
// Dense layer: NUM_OUT parallel dot products over one pooled frame, then
// serial emission of the shifted, saturated neuron results.
module fc_stream_layer #(
    parameter int IN_LEN   = 16,
    parameter int NUM_OUT  = 4,
    parameter int DATA_W   = 22,
    parameter int WEIGHT_W = 8,
    parameter int SHIFT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    fc_stream_layer_if.slave   bus
);
    localparam int AW     = (NUM_OUT * IN_LEN > 1) ? $clog2(NUM_OUT * IN_LEN) : 1;
    localparam int IW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int CNT_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int ACC_W  = PROD_W + $clog2(IN_LEN);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                     state_q, state_d;
    logic signed [WEIGHT_W-1:0] weights_q [NUM_OUT][IN_LEN];
    logic signed [WEIGHT_W-1:0] weights_d [NUM_OUT][IN_LEN];
    logic signed [ACC_W-1:0]    acc_q [NUM_OUT];
    logic signed [ACC_W-1:0]    acc_d [NUM_OUT];
    logic [CNT_W-1:0]           in_cnt_q, in_cnt_d;
    logic [IW-1:0]              out_cnt_q, out_cnt_d;
    logic signed [DATA_W-1:0]   result_out_q, result_out_d;
    logic [IW-1:0]              result_index_q, result_index_d;
    logic                       result_valid_q, result_valid_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;

    logic                       accept;
    logic [CNT_W-1:0]           in_idx;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    shifted;

    always_comb begin
        state_d        = state_q;
        weights_d      = weights_q;
        acc_d          = acc_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        result_out_d   = result_out_q;
        result_index_d = result_index_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        overrun_d      = overrun_q;
        prod           = '0;
        shifted        = '0;

        // A start cycle always accepts its pixel as sample 0, whatever the state.
        accept = bus.pixel_valid && (bus.start_signal || state_q == ACCUM);
        in_idx = bus.start_signal ? '0 : in_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.weight_we) begin
                    for (int unsigned j = 0; j < NUM_OUT; j++) begin
                        for (int unsigned i = 0; i < IN_LEN; i++) begin
                            if (bus.weight_addr == AW'(j * IN_LEN + i))
                                weights_d[j][i] = bus.weight_data;
                        end
                    end
                end
            end
            OUTPUT: begin
                shifted = acc_q[out_cnt_q] >>> SHIFT;
                if (shifted > SAT_MAX)
                    result_out_d = SAT_MAX[DATA_W-1:0];
                else if (shifted < SAT_MIN)
                    result_out_d = SAT_MIN[DATA_W-1:0];
                else
                    result_out_d = shifted[DATA_W-1:0];
                result_valid_d = 1'b1;
                result_index_d = out_cnt_q;
                if (out_cnt_q == IW'(NUM_OUT - 1)) begin
                    done_d    = 1'b1;
                    out_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (bus.pixel_valid && !accept)
            overrun_d = 1'b1;

        if (bus.start_signal) begin
            for (int unsigned j = 0; j < NUM_OUT; j++)
                acc_d[j] = '0;
            in_cnt_d       = '0;
            out_cnt_d      = '0;
            overrun_d      = 1'b0;
            result_valid_d = 1'b0;
            done_d         = 1'b0;
            state_d        = ACCUM;
        end

        if (accept) begin
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                prod     = bus.pixel_in * weights_q[j][in_idx];
                acc_d[j] = acc_d[j] + ACC_W'(prod);
            end
            if (in_idx == CNT_W'(IN_LEN - 1)) begin
                in_cnt_d = '0;
                state_d  = OUTPUT;
            end else begin
                in_cnt_d = in_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            weights_q      <= '{default: '0};
            acc_q          <= '{default: '0};
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            result_out_q   <= '0;
            result_index_q <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            weights_q      <= weights_d;
            acc_q          <= acc_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            result_out_q   <= result_out_d;
            result_index_q <= result_index_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.result_out    = result_out_q;
    assign bus.result_index  = result_index_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.done_signal   = done_q;
    assign bus.overrun_error = overrun_q;
endmodule

// File: tb/tb_fc_stream_layer.sv
// Bench for fc_stream_layer: two instances (SHIFT 0 and 4) share one stimulus
// stream and are compared against an arithmetic dot-product model.
module tb_fc_stream_layer;
    localparam int IN_LEN   = 4;
    localparam int NUM_OUT  = 2;
    localparam int DATA_W   = 22;
    localparam int WEIGHT_W = 8;
    localparam int AW       = 3;
    localparam int SH_A     = 0;
    localparam int SH_B     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fc_stream_layer_if #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) ifa ();
    fc_stream_layer_if #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) ifb ();

    assign ifb.start_signal = ifa.start_signal;
    assign ifb.pixel_valid  = ifa.pixel_valid;
    assign ifb.pixel_in     = ifa.pixel_in;
    assign ifb.weight_we    = ifa.weight_we;
    assign ifb.weight_addr  = ifa.weight_addr;
    assign ifb.weight_data  = ifa.weight_data;

    fc_stream_layer #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .SHIFT(SH_A))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    fc_stream_layer #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .SHIFT(SH_B))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int     n_checks = 0;
    int     n_fail   = 0;
    int     w [NUM_OUT][IN_LEN];
    longint px [IN_LEN];
    bit     ovr_exp;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model(input int k, input int sh);
        longint s = 0;
        longint mx = (longint'(1) <<< (DATA_W - 1)) - 1;
        longint mn = -(longint'(1) <<< (DATA_W - 1));
        for (int i = 0; i < IN_LEN; i++)
            s += px[i] * longint'(w[k][i]);
        s = s >>> sh;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid_a"}, ifa.result_valid, 0);
        check({tag, "_valid_b"}, ifb.result_valid, 0);
        check({tag, "_done_a"},  ifa.done_signal, 0);
        check({tag, "_done_b"},  ifb.done_signal, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_quiet(tag);
        check({tag, "_out_a"}, ifa.result_out, 0);
        check({tag, "_out_b"}, ifb.result_out, 0);
        check({tag, "_idx_a"}, ifa.result_index, 0);
        check({tag, "_ovr_a"}, ifa.overrun_error, 0);
        check({tag, "_ovr_b"}, ifb.overrun_error, 0);
    endtask

    task automatic load_weights();
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int i = 0; i < IN_LEN; i++) begin
                ifa.weight_we   = 1'b1;
                ifa.weight_addr = AW'(j * IN_LEN + i);
                ifa.weight_data = WEIGHT_W'(w[j][i]);
                @(negedge clk);
            end
        end
        ifa.weight_we = 1'b0;
    endtask

    task automatic drive_pixel(input longint v);
        ifa.pixel_valid = 1'b1;
        ifa.pixel_in    = DATA_W'(v);
        @(negedge clk);
        ifa.pixel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ifa.start_signal = 1'b1;
        @(negedge clk);
        ifa.start_signal = 1'b0;
        ovr_exp = 1'b0;
        check("ovr_clr_a", ifa.overrun_error, 0);
        check("ovr_clr_b", ifb.overrun_error, 0);
    endtask

    // Called on the falling edge right after the edge that sampled the last pixel.
    task automatic check_results(input bit poke);
        check_quiet("pre_result");
        for (int k = 0; k < NUM_OUT; k++) begin
            if (poke && k == 0) begin
                ifa.pixel_valid = 1'b1;
                ifa.pixel_in    = DATA_W'($urandom);
                ovr_exp = 1'b1;
            end
            @(negedge clk);
            ifa.pixel_valid = 1'b0;
            check("res_valid_a", ifa.result_valid, 1);
            check("res_valid_b", ifb.result_valid, 1);
            check("res_idx_a", ifa.result_index, k);
            check("res_idx_b", ifb.result_index, k);
            check("res_out_a", ifa.result_out, model(k, SH_A));
            check("res_out_b", ifb.result_out, model(k, SH_B));
            check("res_done_a", ifa.done_signal, (k == NUM_OUT - 1) ? 1 : 0);
            check("res_done_b", ifb.done_signal, (k == NUM_OUT - 1) ? 1 : 0);
        end
        @(negedge clk);
        check_quiet("post_result");
        check("ovr_a", ifa.overrun_error, ovr_exp);
        check("ovr_b", ifb.overrun_error, ovr_exp);
    endtask

    task automatic run_frame(input int maxgap, input bit poke);
        pulse_start();
        for (int i = 0; i < IN_LEN; i++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            drive_pixel(px[i]);
        end
        check_results(poke);
    endtask

    task automatic set_base_weights();
        for (int i = 0; i < IN_LEN; i++) begin
            w[0][i] = i + 1;
            w[1][i] = -1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [DATA_W-1:0] rnd;
        ifa.start_signal = 1'b0;
        ifa.pixel_valid  = 1'b0;
        ifa.pixel_in     = '0;
        ifa.weight_we    = 1'b0;
        ifa.weight_addr  = '0;
        ifa.weight_data  = '0;
        ovr_exp          = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Basic frame, back-to-back then gapped pixels
        set_base_weights();
        load_weights();
        px = '{10, 20, 30, 40};
        run_frame(0, 1'b0);
        run_frame(3, 1'b0);

        // Pixel in IDLE raises the sticky overrun flag
        drive_pixel(7);
        check("idle_ovr_a", ifa.overrun_error, 1);
        check("idle_ovr_b", ifb.overrun_error, 1);
        check_quiet("idle_px");

        // Saturation both ways
        foreach (w[j, i]) w[j][i] = 127;
        load_weights();
        px = '{2097151, 2097151, 2097151, 2097151};
        run_frame(1, 1'b0);
        foreach (w[j, i]) w[j][i] = -128;
        load_weights();
        run_frame(1, 1'b0);

        // Pixel during OUTPUT: dropped, results unchanged, overrun set
        set_base_weights();
        load_weights();
        px = '{10, 20, 30, 40};
        run_frame(0, 1'b1);
        run_frame(2, 1'b0);

        // Restart mid-frame with a pixel on the start cycle
        pulse_start();
        drive_pixel(100);
        drive_pixel(200);
        ifa.start_signal = 1'b1;
        ovr_exp = 1'b0;
        drive_pixel(5);
        ifa.start_signal = 1'b0;
        drive_pixel(1);
        drive_pixel(1);
        drive_pixel(1);
        px = '{5, 1, 1, 1};
        check_results(1'b0);

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            foreach (w[j, i]) w[j][i] = int'($urandom_range(255)) - 128;
            load_weights();
            for (int i = 0; i < IN_LEN; i++) begin
                if (r % 2 == 0) begin
                    rnd   = DATA_W'($urandom);
                    px[i] = longint'(rnd);
                end else begin
                    px[i] = longint'($urandom_range(8000)) - 4000;
                end
            end
            run_frame(2, 1'b0);
        end

        // Async reset mid-ACCUM
        set_base_weights();
        load_weights();
        px = '{10, 20, 30, 40};
        run_frame(0, 1'b0);
        pulse_start();
        drive_pixel(11);
        drive_pixel(12);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_accum");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Async reset mid-OUTPUT
        load_weights();
        pulse_start();
        for (int i = 0; i < IN_LEN; i++) drive_pixel(px[i]);
        @(negedge clk);
        check("mid_out_valid", ifa.result_valid, 1);
        check("mid_out_val", ifa.result_out, model(0, SH_A));
        #2 rst = 1'b0;
        #1 check_all_zero("rst_output");
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_quiet("after_rst");
        end

        // Weights were cleared by reset
        foreach (w[j, i]) w[j][i] = 0;
        px = '{10, 20, 30, 40};
        run_frame(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fc_stream_layer.md
Name: fc_stream_layer

Overview:
Fully-connected (dense) stage directly downstream of the ReLU + max-pooling stage. Consumes the pooled 22-bit signed stream (result_out/result_valid/done_signal of the pooling stage) and computes NUM_OUT dot products against a register-held weight matrix in parallel. It then emits the NUM_OUT scaled, saturated results serially. It is the classifier head of the mini NPU pipeline.

Parameters:
IN_LEN, 16, number of pooled samples per frame (dot-product length)
NUM_OUT, 4, number of output neurons
DATA_W, 22, signed width of pixel_in and result_out
WEIGHT_W, 8, signed weight width
SHIFT, 0, arithmetic right shift applied to each accumulator before saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start_signal  in  1  frame start; clears accumulators/counters
pixel_valid  in  1  pixel_in qualifier (from pooling result_valid)
pixel_in  in  DATA_W  signed pooled sample
weight_we  in  1  weight write strobe
weight_addr  in  clog2(NUM_OUT*IN_LEN)  address = out_idx*IN_LEN + in_idx
weight_data  in  WEIGHT_W  signed weight
result_out  out  DATA_W  signed neuron result
result_index  out  clog2(NUM_OUT)  neuron index of result_out
result_valid  out  1  result_out/result_index valid
done_signal  out  1  one-cycle pulse with the last result
overrun_error  out  1  sticky: pixel arrived when not accepting

Behaviour:
- Reset (rst=0, async): state IDLE; all accumulators, counters, weights = 0; result_out=0, result_index=0, result_valid=0, done_signal=0, overrun_error=0.
- Widths: product = DATA_W+WEIGHT_W signed (30). ACC_W = DATA_W+WEIGHT_W+clog2(IN_LEN), so accumulation never overflows. Output = acc >>> SHIFT (arithmetic, truncate toward -inf). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- States: IDLE, ACCUM, OUTPUT.
- IDLE: pixel_valid ignored and sets overrun_error. weight_we writes weight[weight_addr]; an out-of-range address is ignored. start_signal -> ACCUM.
- start_signal in any state: clears all acc, in_cnt, out_cnt, overrun_error; next state ACCUM. It aborts an in-progress OUTPUT, with no further result_valid. A pixel_valid in the same cycle as start_signal is accepted as sample 0 (acc[j] = pixel_in*weight[j][0]).
- ACCUM: each pixel_valid cycle, for all j in parallel, acc[j] += pixel_in*weight[j][in_cnt], and in_cnt++. Gaps in pixel_valid are allowed with no timeout. The pixel accepted with in_cnt==IN_LEN-1 moves the state to OUTPUT. weight_we is ignored outside IDLE.
- OUTPUT: if the last pixel is sampled at edge T, result k (k=0..NUM_OUT-1) is registered at edge T+1+k: result_valid=1, result_index=k, result_out=sat(acc[k]>>>SHIFT). done_signal=1 only with k=NUM_OUT-1. The edge after that returns to IDLE with result_valid=0 and done_signal=0. pixel_valid during OUTPUT is dropped and sets overrun_error.
- overrun_error stays high until start_signal or reset.
- Weights persist across frames; they are cleared only by reset.
- result_valid is never asserted for a partial frame. If reset occurs mid-ACCUM or mid-OUTPUT, outputs clear immediately and no further results appear.

Test Plan:
- IN_LEN=4, NUM_OUT=2, SHIFT=0; weights out0={1,2,3,4}, out1={-1,-1,-1,-1}; start, then pixels 10,20,30,40 back-to-back -> results (idx0,300) then (idx1,-100) on consecutive cycles starting 1 cycle after the last pixel; done_signal with idx1.
- Same weights, pixels with 0-3 idle cycles between them -> identical results, overrun_error=0.
- All weights 127, four pixels of 2097151 -> both results saturate to 2097151. Weights -128 -> -2097152. SHIFT=4 with the first test -> 18 and -7.
- Drive a 5th pixel during OUTPUT, then a pixel in IDLE -> results unchanged, overrun_error=1 until the next start_signal clears it.
- Start, two pixels, then start_signal again together with a pixel of 5 followed by 1,1,1 -> out0 = 5*1+2+3+4 = 14; the earlier partial sums are discarded.
- Assert rst low asynchronously mid-ACCUM and mid-OUTPUT -> all outputs go to 0 immediately. After release, the weights read as 0: a frame gives results of 0.
